// File: rtl/ddr_dram_rw_responder_pkg.sv
// Shared types for the DRAM-side read/write responder: command kind, queued CAS entry,
// burst FSM states and the in-block burst address helper.
package ddr_dram_rw_responder_pkg;

    localparam int CAS_COL_W = 10;
    localparam int CAS_TS_W  = 8;

    typedef enum logic {
        WR_R = 1'b0,
        RD_R = 1'b1
    } rw_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        BURST
    } rsp_state_t;

    typedef struct packed {
        rw_cmd_t                is_rd;
        logic [CAS_COL_W-1:0]   col;
        logic                   bc4;
        logic [CAS_TS_W-1:0]    due;
    } cas_entry_t;

    // Word index of burst cycle k; the column wraps inside its aligned 2- or 4-word block.
    function automatic logic [CAS_COL_W-2:0] burst_idx(input logic [CAS_COL_W-1:0] col,
                                                       input logic                 bc4,
                                                       input logic [1:0]           k);
        logic [CAS_COL_W-2:0] w;
        w = col[CAS_COL_W-1:1];
        if (bc4) w[0]   = w[0] ^ k[0];
        else     w[1:0] = w[1:0] + k;
        return w;
    endfunction

endpackage

// File: rtl/ddr_cas_fifo.sv
// Synchronous FIFO of pending CAS entries. A push while full is ignored even if a pop
// happens on the same edge.
module ddr_cas_fifo
    import ddr_dram_rw_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  cas_entry_t                   din,
    input  logic                         pop,
    output cas_entry_t                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cas_entry_t    store [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr_dram_rw_responder.sv
// DRAM-side CAS responder: timestamps RD/WR commands, then plays read bursts out of
// (or captures write bursts into) the internal array once their latency has elapsed.
module ddr_dram_rw_responder
    import ddr_dram_rw_responder_pkg::*;
#(
    parameter int DQ_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic                         CK_t,
    input  logic                         reset_n,
    input  logic                         cas_valid,
    input  logic                         cas_is_rd,
    input  logic [CAS_COL_W-1:0]         cas_col,
    input  logic [5:0]                   cl,
    input  logic [5:0]                   cwl,
    input  logic [5:0]                   al,
    input  logic                         bc4,
    input  logic [1:0]                   rd_pre,
    input  logic [2*DQ_W-1:0]            wr_dq,
    output logic [2*DQ_W-1:0]            rd_dq,
    output logic                         rd_valid,
    output logic                         dqs_oe,
    output logic                         wr_capture,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         err_overflow,
    output logic                         err_collide
);

    // Column and timestamp widths are fixed by cas_entry_t in the package.
    localparam int COL_W = CAS_COL_W;
    localparam int TS_W  = CAS_TS_W;

    logic [TS_W-1:0]    ts;
    cas_entry_t         new_entry, head;
    logic               fifo_full, fifo_empty, pop;

    rsp_state_t         state, nstate;
    logic [1:0]         k, nk;
    rw_cmd_t            cur_rd, n_rd;
    logic [COL_W-1:0]   cur_col, n_col;
    logic               cur_bc4, n_bc4;
    logic               last, start;

    logic [TS_W-1:0]    due_diff, pre_diff;
    logic               due_now, pre_now, collide;

    logic [2*DQ_W-1:0]  mem [2**(COL_W-1)];
    logic [2*DQ_W-1:0]  rd_word;

    always_comb begin
        new_entry       = '0;
        new_entry.is_rd = rw_cmd_t'(cas_is_rd);
        new_entry.col   = cas_col;
        new_entry.bc4   = bc4;
        new_entry.due   = ts + TS_W'(al) + TS_W'(cas_is_rd ? cl : cwl);
    end

    ddr_cas_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CK_t),
        .reset_n (reset_n),
        .push    (cas_valid),
        .din     (new_entry),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (pending)
    );

    // Sign bit of the modular difference gives a wrap-safe "ts has reached due".
    assign due_diff = ts - head.due;
    assign pre_diff = ts + TS_W'(rd_pre) - head.due;
    assign due_now  = !fifo_empty && !due_diff[TS_W-1];
    assign pre_now  = !fifo_empty && (head.is_rd == RD_R) && (rd_pre != 2'd0)
                      && !pre_diff[TS_W-1];

    assign last    = cur_bc4 ? (k == 2'd1) : (k == 2'd3);
    assign collide = (state == BURST) && !last && due_now;

    always_comb begin
        nstate = state;
        nk     = k;
        n_rd   = cur_rd;
        n_col  = cur_col;
        n_bc4  = cur_bc4;
        start  = 1'b0;
        case (state)
            IDLE: begin
                if (due_now)      start  = 1'b1;
                else if (pre_now) nstate = PRE;
            end
            PRE: begin
                if (due_now) start = 1'b1;
            end
            BURST: begin
                if (!last)        nk     = k + 2'd1;
                else if (due_now) start  = 1'b1;
                else if (pre_now) nstate = PRE;
                else              nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        if (start) begin
            nstate = BURST;
            nk     = 2'd0;
            n_rd   = head.is_rd;
            n_col  = head.col;
            n_bc4  = head.bc4;
        end
    end

    assign pop     = start;
    assign rd_word = mem[burst_idx(n_col, n_bc4, nk)];

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            ts           <= '0;
            state        <= IDLE;
            k            <= '0;
            cur_rd       <= WR_R;
            cur_col      <= '0;
            cur_bc4      <= 1'b0;
            rd_dq        <= '0;
            err_overflow <= 1'b0;
            err_collide  <= 1'b0;
        end else begin
            ts           <= ts + TS_W'(1);
            state        <= nstate;
            k            <= nk;
            cur_rd       <= n_rd;
            cur_col      <= n_col;
            cur_bc4      <= n_bc4;
            rd_dq        <= (nstate == BURST && n_rd == RD_R) ? rd_word : '0;
            err_overflow <= err_overflow | (cas_valid && fifo_full);
            err_collide  <= err_collide | collide;
        end
    end

    // Array has no reset; a write beat on the reset edge is discarded with the burst.
    always_ff @(posedge CK_t) begin
        if (reset_n && wr_capture) mem[burst_idx(cur_col, cur_bc4, k)] <= wr_dq;
    end

    assign rd_valid   = (state == BURST) && (cur_rd == RD_R);
    assign wr_capture = (state == BURST) && (cur_rd == WR_R);
    assign dqs_oe     = (state == PRE) || rd_valid;
    assign busy       = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_ddr_dram_rw_responder.sv
// Directed bench for ddr_dram_rw_responder: latency, burst wrap, back-to-back, collision,
// overflow, reset-mid-burst and timestamp wrap, with hand-computed expectations.
module tb_ddr_dram_rw_responder;

    logic        CK_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cas_valid = 1'b0;
    logic        cas_is_rd = 1'b0;
    logic [9:0]  cas_col = '0;
    logic [5:0]  cl = 6'd11, cwl = 6'd9, al = 6'd0;
    logic        bc4 = 1'b0;
    logic [1:0]  rd_pre = 2'd0;
    logic [15:0] wr_dq = '0;
    logic [15:0] rd_dq;
    logic        rd_valid, dqs_oe, wr_capture, busy, err_overflow, err_collide;
    logic [3:0]  pending;

    int tests = 0;
    int fails = 0;

    ddr_dram_rw_responder #(.DQ_W(8), .DEPTH(8)) dut (
        .CK_t         (CK_t),
        .reset_n      (reset_n),
        .cas_valid    (cas_valid),
        .cas_is_rd    (cas_is_rd),
        .cas_col      (cas_col),
        .cl           (cl),
        .cwl          (cwl),
        .al           (al),
        .bc4          (bc4),
        .rd_pre       (rd_pre),
        .wr_dq        (wr_dq),
        .rd_dq        (rd_dq),
        .rd_valid     (rd_valid),
        .dqs_oe       (dqs_oe),
        .wr_capture   (wr_capture),
        .busy         (busy),
        .pending      (pending),
        .err_overflow (err_overflow),
        .err_collide  (err_collide)
    );

    always #5 CK_t = ~CK_t;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CK_t);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Drives one CAS for a single edge; returns in cycle 0 of that command.
    task automatic cas(input logic rd, input logic [9:0] col, input logic b);
        cas_valid = 1'b1;
        cas_is_rd = rd;
        cas_col   = col;
        bc4       = b;
        tick();
        cas_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_dq"}, 32'(rd_dq), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_dqs_oe"}, 32'(dqs_oe), 0);
        chk({tag, "_wr_capture"}, 32'(wr_capture), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 0);
        chk({tag, "_err_collide"}, 32'(err_collide), 0);
    endtask

    // BL8/BC4 write with data base+k, latency al+cwl.
    task automatic wr_burst(input string tag, input logic [9:0] col, input logic b,
                            input int lat, input logic [15:0] base);
        cas(1'b0, col, b);
        tick(lat);
        for (int i = 0; i < (b ? 2 : 4); i++) begin
            chk({tag, "_cap"}, 32'(wr_capture), 1);
            wr_dq = base + 16'(i);
            tick();
        end
        chk({tag, "_cap_end"}, 32'(wr_capture), 0);
    endtask

    initial begin
        logic [15:0] exp4b [8];
        int          cnt;
        exp4b = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd0, 16'd1, 16'd2};

        // reset state
        tick(2);
        check_zero("reset");
        reset_n = 1'b1;

        // preload words 0..3 = 0..3 and words 8..11 = B000..B003
        wr_burst("pre0", 10'd0, 1'b0, 9, 16'h0000);
        wr_burst("pre8", 10'd16, 1'b0, 9, 16'hB000);

        // 1: read col 0, cl=11, preamble 1
        rd_pre = 2'd1;
        cas(1'b1, 10'd0, 1'b0);
        tick(9);
        chk("t1_dqs_c9", 32'(dqs_oe), 0);
        tick();
        chk("t1_dqs_c10", 32'(dqs_oe), 1);
        chk("t1_rdv_c10", 32'(rd_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rdv", 32'(rd_valid), 1);
            chk("t1_dqs", 32'(dqs_oe), 1);
            chk("t1_data", 32'(rd_dq), 32'(i));
        end
        tick();
        chk("t1_rdv_end", 32'(rd_valid), 0);
        chk("t1_dqs_end", 32'(dqs_oe), 0);
        rd_pre = 2'd0;

        // 3: read col 6 BL8 wraps inside block -> words 3,0,1,2
        cas(1'b1, 10'd6, 1'b0);
        tick(11);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rdv", 32'(rd_valid), 1);
            chk("t3_data", 32'(rd_dq), 32'((i + 3) % 4));
            tick();
        end

        // 4a: two reads 4 cycles apart -> 8 contiguous cycles, no collision
        cas(1'b1, 10'd0, 1'b0);
        tick(3);
        cas(1'b1, 10'd0, 1'b0);
        tick(7);
        for (int i = 0; i < 8; i++) begin
            chk("t4a_rdv", 32'(rd_valid), 1);
            chk("t4a_data", 32'(rd_dq), 32'(i % 4));
            tick();
        end
        chk("t4a_rdv_end", 32'(rd_valid), 0);
        chk("t4a_collide", 32'(err_collide), 0);

        // 4b: two reads 2 cycles apart -> collision, second burst starts at cycle 15
        do_reset();
        cas(1'b1, 10'd0, 1'b0);
        tick(1);
        cas(1'b1, 10'd6, 1'b0);
        tick(9);
        for (int i = 0; i < 8; i++) begin
            chk("t4b_rdv", 32'(rd_valid), 1);
            chk("t4b_data", 32'(rd_dq), 32'(exp4b[i]));
            chk("t4b_collide", 32'(err_collide), (i >= 2) ? 1 : 0);
            tick();
        end
        chk("t4b_rdv_end", 32'(rd_valid), 0);
        chk("t4b_collide_end", 32'(err_collide), 1);

        // 2: BC4 write col 4 with al=2, cwl=9, then read it back
        do_reset();
        al = 6'd2;
        cas(1'b0, 10'd4, 1'b1);
        tick(10);
        chk("t2_cap_c10", 32'(wr_capture), 0);
        tick();
        chk("t2_cap_c11", 32'(wr_capture), 1);
        wr_dq = 16'hAAAA;
        tick();
        chk("t2_cap_c12", 32'(wr_capture), 1);
        wr_dq = 16'h5555;
        tick();
        chk("t2_cap_c13", 32'(wr_capture), 0);
        cas(1'b1, 10'd4, 1'b1);
        tick(13);
        chk("t2_rdv0", 32'(rd_valid), 1);
        chk("t2_data0", 32'(rd_dq), 32'h0000AAAA);
        tick();
        chk("t2_data1", 32'(rd_dq), 32'h00005555);
        tick();
        chk("t2_rdv_end", 32'(rd_valid), 0);
        al = 6'd0;

        // 5: DEPTH+1 commands -> one dropped, exactly 8 bursts
        do_reset();
        cl = 6'd40;
        for (int i = 0; i < 9; i++) cas(1'b1, 10'd0, 1'b0);
        chk("t5_pending", 32'(pending), 8);
        chk("t5_overflow", 32'(err_overflow), 1);
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (rd_valid) cnt++;
            tick();
        end
        chk("t5_burst_cycles", 32'(cnt), 32);
        chk("t5_busy_end", 32'(busy), 0);
        chk("t5_pending_end", 32'(pending), 0);
        chk("t5_collide", 32'(err_collide), 1);

        // 6: reset during write burst k=1; array keeps what was written
        do_reset();
        cas(1'b0, 10'd16, 1'b0);
        cas(1'b1, 10'd0, 1'b0);
        tick(8);
        chk("t6_cap_k0", 32'(wr_capture), 1);
        wr_dq = 16'hA000;
        tick();
        chk("t6_cap_k1", 32'(wr_capture), 1);
        chk("t6_pending", 32'(pending), 1);
        reset_n = 1'b0;
        wr_dq = 16'hA001;
        tick();
        reset_n = 1'b1;
        check_zero("t6_after_reset");
        cl = 6'd11;
        cas(1'b1, 10'd16, 1'b0);
        tick(11);
        chk("t6_word8", 32'(rd_dq), 32'h0000A000);
        tick(2);
        chk("t6_word10", 32'(rd_dq), 32'h0000B002);
        tick();
        chk("t6_word11", 32'(rd_dq), 32'h0000B003);
        tick(2);

        // 7: command issued at ts = 2**TS_W-5, due wraps past zero
        do_reset();
        tick(251);
        cas(1'b1, 10'd0, 1'b0);
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rd_valid) cnt++;
        end
        chk("t7_early_rdv", 32'(cnt), 0);
        tick();
        chk("t7_rdv_c11", 32'(rd_valid), 1);
        chk("t7_data", 32'(rd_dq), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
